atmega_pcint: RTL and testbench

Pin-change interrupt controller for one ATmega-style port group. It sits directly downstream of the raw pad inputs that feed the port's PIO block, tapping the same `io_in` vector. It synchronises the pins, detects any toggle on pins enabled in PCMSK, latches the PCIF flag and raises an interrupt request to the core's interrupt controller. Its registers are accessed over the same 8-bit peripheral bus as the PIO.

---
 rtl/atmega_io_pkg.sv | 29 ++
 rtl/atmega_sync.sv | 24 ++
 rtl/atmega_pcint.sv | 109 ++++++++++
 tb/tb_atmega_pcint.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/atmega_io_pkg.sv
// Shared definitions for the ATmega-style I/O peripherals (PIO, PCINT).
package atmega_io_pkg;

    // Default PCINT register offsets on the peripheral bus
    localparam int PCINT_PCICR_OFS = 'h00;
    localparam int PCINT_PCIFR_OFS = 'h01;
    localparam int PCINT_PCMSK_OFS = 'h02;

    // Bit positions inside PCICR / PCIFR
    localparam int PCIE_BIT = 0;
    localparam int PCIF_BIT = 0;

    // Pin-change warm-up sequencer states
    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } warm_state_t;

    // Number of low address bits ignored when registers are wider than a byte
    function automatic int bus_len_shift(input int port_width);
        if (port_width > 16)
            return 2;
        else if (port_width > 8)
            return 1;
        else
            return 0;
    endfunction

endpackage

// File: rtl/atmega_sync.sv
// Parameterised N-stage, W-bit flop synchroniser for asynchronous inputs.
module atmega_sync #(
    parameter int STAGES = 2,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] sync_pipe;

    // Shift the raw inputs through the flop chain; stage 0 takes the pads
    always_ff @(posedge clk) begin
        if (rst)
            sync_pipe <= '0;
        else
            sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/atmega_pcint.sv
// Pin-change interrupt controller for one port group: synchronises the pads,
// detects toggles on enabled pins, latches PCIF and requests an interrupt.
module atmega_pcint
    import atmega_io_pkg::*;
#(
    parameter int                           BUS_ADDR_DATA_LEN = 8,
    parameter int                           PORT_WIDTH        = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCICR_ADDR        = BUS_ADDR_DATA_LEN'(PCINT_PCICR_OFS),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR        = BUS_ADDR_DATA_LEN'(PCINT_PCIFR_OFS),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR        = BUS_ADDR_DATA_LEN'(PCINT_PCMSK_OFS),
    parameter int                           SYNC_STAGES       = 2,
    parameter logic [PORT_WIDTH-1:0]        PINMASK           = '1
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [PORT_WIDTH-1:0]        bus_in,
    output logic [PORT_WIDTH-1:0]        bus_out,
    input  logic [PORT_WIDTH-1:0]        io_in,
    input  logic                         int_ack,
    output logic                         int_out
);

    localparam int SH = bus_len_shift(PORT_WIDTH);
    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic                  hit_pcicr, hit_pcifr, hit_pcmsk;
    logic [PORT_WIDTH-1:0] sync, prev, chg, pcmsk;
    logic                  pcie, pcif, pcif_clr;
    warm_state_t           state;
    logic [CW-1:0]         warm_cnt;

    assign hit_pcicr = addr[BUS_ADDR_DATA_LEN-1:SH] == PCICR_ADDR[BUS_ADDR_DATA_LEN-1:SH];
    assign hit_pcifr = addr[BUS_ADDR_DATA_LEN-1:SH] == PCIFR_ADDR[BUS_ADDR_DATA_LEN-1:SH];
    assign hit_pcmsk = addr[BUS_ADDR_DATA_LEN-1:SH] == PCMSK_ADDR[BUS_ADDR_DATA_LEN-1:SH];

    atmega_sync #(
        .STAGES (SYNC_STAGES),
        .W      (PORT_WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (io_in),
        .q   (sync)
    );

    // Edges are suppressed until the synchroniser and prev have both
    // settled on the real pad levels, so pins high out of reset are silent.
    assign chg = (state == ST_RUN) ? ((sync ^ prev) & pcmsk & PINMASK) : '0;

    // ack and a W1C write collapse into one clear request
    assign pcif_clr = int_ack | (wr & hit_pcifr & bus_in[PCIF_BIT]);

    // Warm-up sequencer: count SYNC_STAGES cycles after reset, then run forever
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WARMUP;
            warm_cnt <= '0;
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (warm_cnt == CW'(SYNC_STAGES))
                        state <= ST_RUN;
                    else
                        warm_cnt <= warm_cnt + 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Register file, edge history and the PCIF latch (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            pcie  <= 1'b0;
            pcif  <= 1'b0;
            pcmsk <= '0;
            prev  <= '0;
        end else begin
            prev <= sync;
            if (wr && hit_pcicr)
                pcie <= bus_in[PCIE_BIT];
            if (wr && hit_pcmsk)
                pcmsk <= bus_in & PINMASK;
            if (|chg)
                pcif <= 1'b1;
            else if (pcif_clr)
                pcif <= 1'b0;
        end
    end

    // Combinational read mux, silent unless a read strobe is present
    always_comb begin
        bus_out = '0;
        if (rd && !rst) begin
            if (hit_pcicr)
                bus_out[PCIE_BIT] = pcie;
            else if (hit_pcifr)
                bus_out[PCIF_BIT] = pcif;
            else if (hit_pcmsk)
                bus_out = pcmsk;
        end
    end

    assign int_out = pcif & pcie;

endmodule

// File: tb/tb_atmega_pcint.sv
// Directed bench for atmega_pcint: full-pin instance plus a PINMASK='h0F one.
module tb_atmega_pcint;

    localparam logic [7:0] A_PCICR = 8'h00;
    localparam logic [7:0] A_PCIFR = 8'h01;
    localparam logic [7:0] A_PCMSK = 8'h02;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       wr, rd, int_ack;
    logic [7:0] bus_in, io_in;
    logic [7:0] bus_out, bus_out_pm;
    logic       int_out, int_out_pm;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    atmega_pcint dut (
        .rst     (rst),
        .clk     (clk),
        .addr    (addr),
        .wr      (wr),
        .rd      (rd),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .io_in   (io_in),
        .int_ack (int_ack),
        .int_out (int_out)
    );

    atmega_pcint #(.PINMASK(8'h0F)) dut_pm (
        .rst     (rst),
        .clk     (clk),
        .addr    (addr),
        .wr      (wr),
        .rd      (rd),
        .bus_in  (bus_in),
        .bus_out (bus_out_pm),
        .io_in   (io_in),
        .int_ack (int_ack),
        .int_out (int_out_pm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
        tick();
        wr     = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d, output logic [7:0] dpm);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = bus_out;
        dpm  = bus_out_pm;
        rd   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, dpm;
        rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; int_ack = 1'b0;
        bus_in = '0; io_in = 8'hFF;
        tick(2);
        chk("rst_int_out", int_out, 0);
        chk("rst_bus_out_idle", bus_out, 0);

        // 1: pins high out of reset must not flag during warm-up
        rst = 1'b0;
        bus_wr(A_PCMSK, 8'hFF);
        bus_wr(A_PCICR, 8'h01);
        for (int i = 0; i < 18; i++) begin
            chk("t1_int_out_quiet", int_out, 0);
            tick();
        end
        bus_rd(A_PCIFR, d, dpm);
        chk("t1_pcifr", d, 0);
        bus_rd(A_PCMSK, d, dpm);
        chk("t1_pcmsk", d, 8'hFF);
        chk("t1_pcmsk_pm", dpm, 8'h0F);

        // settle all pins low with no enables, then enable pin 2 only
        bus_wr(A_PCMSK, 8'h00);
        io_in = 8'h00;
        tick(4);
        bus_wr(A_PCMSK, 8'h04);
        bus_rd(A_PCIFR, d, dpm);
        chk("t2_pcifr_pre", d, 0);

        // 2: toggle pin 2, flag appears after E+2
        io_in = 8'h04;
        tick();
        chk("t2_lat_e0", int_out, 0);
        tick();
        chk("t2_lat_e1", int_out, 0);
        tick();
        chk("t2_lat_e2", int_out, 1);
        chk("t2_lat_e2_pm", int_out_pm, 1);
        bus_wr(A_PCIFR, 8'h01);
        chk("t2_w1c", int_out, 0);
        chk("t2_w1c_pm", int_out_pm, 0);

        // 3: unmasked pin ignored; absent pins not writable and never trigger
        io_in = 8'h0C;
        tick(4);
        bus_rd(A_PCIFR, d, dpm);
        chk("t3_unmasked_pcif", d, 0);
        bus_wr(A_PCMSK, 8'hF0);
        bus_rd(A_PCMSK, d, dpm);
        chk("t3_pcmsk_full", d, 8'hF0);
        chk("t3_pcmsk_pm", dpm, 8'h00);
        io_in = 8'h8C;
        tick(4);
        chk("t3_pin7_full", int_out, 1);
        chk("t3_pin7_pm", int_out_pm, 0);
        bus_wr(A_PCIFR, 8'h00);
        chk("t3_w0_no_clear", int_out, 1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t3_ack_clear", int_out, 0);

        // 4: change event coincident with ack / W1C keeps PCIF set
        io_in = 8'hAC;
        tick(3);
        chk("t4_set", int_out, 1);
        io_in = 8'hEC;
        tick(2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t4_set_beats_ack", int_out, 1);
        bus_rd(A_PCIFR, d, dpm);
        chk("t4_pcifr", d, 8'h01);
        io_in = 8'hFC;
        tick(2);
        addr = A_PCIFR; bus_in = 8'h01; wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("t4_set_beats_w1c", int_out, 1);
        addr = A_PCIFR; bus_in = 8'h01; wr = 1'b1; int_ack = 1'b1;
        tick();
        wr = 1'b0; int_ack = 1'b0;
        chk("t4_dual_clear", int_out, 0);
        tick();
        chk("t4_dual_clear_hold", int_out, 0);

        // 5: PCIE masks the request but PCIF still latches
        bus_wr(A_PCICR, 8'h00);
        io_in = 8'hEC;
        tick(3);
        chk("t5_masked", int_out, 0);
        bus_rd(A_PCIFR, d, dpm);
        chk("t5_pcifr", d, 8'h01);
        bus_rd(A_PCICR, d, dpm);
        chk("t5_pcicr", d, 8'h00);
        bus_wr(A_PCICR, 8'h01);
        chk("t5_unmask", int_out, 1);

        // 6: reset drops pending flag; toggles during warm-up are ignored
        rst = 1'b1;
        addr = A_PCMSK; rd = 1'b1;
        #1;
        chk("t6_rd_in_rst", bus_out, 0);
        rd = 1'b0;
        tick();
        chk("t6_rst_int_out", int_out, 0);
        rst = 1'b0;
        io_in = 8'h13;
        bus_rd(A_PCICR, d, dpm);
        chk("t6_pcicr", d, 0);
        bus_rd(A_PCIFR, d, dpm);
        chk("t6_pcifr", d, 0);
        bus_rd(A_PCMSK, d, dpm);
        chk("t6_pcmsk", d, 0);
        bus_wr(A_PCMSK, 8'hFF);
        bus_wr(A_PCICR, 8'h01);
        for (int i = 0; i < 6; i++) begin
            chk("t6_warm_quiet", int_out, 0);
            tick();
        end
        bus_rd(A_PCIFR, d, dpm);
        chk("t6_warm_pcifr", d, 0);
        io_in = 8'h12;
        tick(3);
        chk("t6_run_again", int_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
